// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_adder_ctrl.
// Define CLA_SEQ_GROUP_PG_EN to carry the whole-width group P/G signals.
interface cla_seq_adder_ctrl_if #(
    parameter int CHUNKS = 2
) ();
    localparam int W = CHUNKS * 23;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_SEQ_GROUP_PG_EN
    logic         p_all;
    logic         g_all;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, p_all, g_all);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, p_all, g_all);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Wide (CHUNKS x 23-bit) adder that time-shares one CLA_23bit, LSB chunk first.
// Define CLA_SEQ_GROUP_PG_EN to add the p_all/g_all group propagate/generate outputs.

module CLA_23bit (
    input  logic [22:0] A,
    input  logic [22:0] B,
    input  logic        cin,
    output logic [22:0] S,
    output logic        cout,
    output logic        P,
    output logic        G
);
    // Kogge-Stone prefix: level 5 holds generate/propagate over bits [i:0]
    logic [5:0][22:0] gk;
    logic [5:0][22:0] pk;
    logic [22:0]      c_in;

    always_comb begin
        gk[0] = A & B;
        pk[0] = A ^ B;
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 23; i++) begin
                if (i >= (1 << l)) begin
                    gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
                    pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
                end else begin
                    gk[l+1][i] = gk[l][i];
                    pk[l+1][i] = pk[l][i];
                end
            end
        end
    end

    assign c_in = {gk[5][21:0] | (pk[5][21:0] & {22{cin}}), cin};
    assign S    = pk[0] ^ c_in;
    assign cout = gk[5][22] | (pk[5][22] & cin);
    assign P    = pk[5][22];
    assign G    = gk[5][22];
endmodule

module cla_seq_adder_ctrl #(
    parameter  int CHUNKS = 2,
    localparam int W      = CHUNKS * 23
) (
    input logic                 clk,
    input logic                 rst,
    cla_seq_adder_ctrl_if.slave bus
);
    localparam int            IW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef logic [CHUNKS-1:0][22:0] wide_t;

    state_e        state_q, state_d;
    wide_t         a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          cin_q, cin_d, c_q, c_d, cout_q, cout_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          accept;
    logic [22:0]   cla_s;
    logic          cla_co;
`ifdef CLA_SEQ_GROUP_PG_EN
    logic          cla_p, cla_g;
    logic          p_acc_q, p_acc_d, g_acc_q, g_acc_d;
`else
    logic          cla_p_unused, cla_g_unused;
`endif

    CLA_23bit u_cla (
        .A    (a_q[idx_q]),
        .B    (b_q[idx_q]),
        .cin  ((idx_q == '0) ? cin_q : c_q),
        .S    (cla_s),
        .cout (cla_co),
`ifdef CLA_SEQ_GROUP_PG_EN
        .P    (cla_p),
        .G    (cla_g)
`else
        .P    (cla_p_unused),
        .G    (cla_g_unused)
`endif
    );

    // A finishing result can be handed off and a new op taken on the same edge
    assign bus.in_ready  = !rst && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = W'(sum_q);
    assign bus.cout      = cout_q;
`ifdef CLA_SEQ_GROUP_PG_EN
    assign bus.p_all     = p_acc_q;
    assign bus.g_all     = g_acc_q;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        c_d     = c_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_GROUP_PG_EN
        p_acc_d = p_acc_q;
        g_acc_d = g_acc_q;
`endif
        case (state_q)
            IDLE: ;
            RUN: begin
                sum_d[idx_q] = cla_s;
                c_d          = cla_co;
                idx_d        = idx_q + 1'b1;
`ifdef CLA_SEQ_GROUP_PG_EN
                if (idx_q == '0) begin
                    p_acc_d = cla_p;
                    g_acc_d = cla_g;
                end else begin
                    p_acc_d = p_acc_q & cla_p;
                    g_acc_d = cla_g | (cla_p & g_acc_q);
                end
`endif
                if (idx_q == LAST) begin
                    cout_d  = cla_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            cin_d   = bus.cin;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_GROUP_PG_EN
            p_acc_q <= 1'b0;
            g_acc_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CLA_SEQ_GROUP_PG_EN
            p_acc_q <= p_acc_d;
            g_acc_q <= g_acc_d;
`endif
        end
    end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl: directed checks on CHUNKS=2 plus random
// handshake regressions on CHUNKS=1 and CHUNKS=4 against a transaction model.
module tb_cla_seq_adder_ctrl;
    localparam int N_OPS = 1000;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   rnd_go = 1'b0;
    bit   rdone [3] = '{1'b0, 1'b0, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : u
        localparam int CH = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        localparam int WW = CH * 23;
        localparam int WP = WW + 1;

        cla_seq_adder_ctrl_if #(.CHUNKS(CH)) bif ();
        cla_seq_adder_ctrl #(.CHUNKS(CH)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bif)
        );

        // Transaction model: one op in flight, result due CH edges after accept
        logic          pend  = 1'b0;
        int            cyc   = 0;
        int            due   = 0;
        int            n_res = 0;
        logic [WW:0]   res   = '0;
        wire  [WW:0]   add_nc = WP'(bif.a) + WP'(bif.b);
        wire           m_ov   = pend && (cyc >= due);
        wire           m_rdy  = !rst && (!pend || (m_ov && bif.out_ready));
`ifdef CLA_SEQ_GROUP_PG_EN
        logic          p_exp = 1'b0;
        logic          g_exp = 1'b0;
`endif

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                pend <= 1'b0;
                cyc  <= 0;
            end else begin
                cyc <= cyc + 1;
                if (m_ov && bif.out_ready) n_res <= n_res + 1;
                if (bif.in_valid && m_rdy) begin
                    pend <= 1'b1;
                    due  <= cyc + 1 + CH;
                    res  <= add_nc + WP'(bif.cin);
`ifdef CLA_SEQ_GROUP_PG_EN
                    p_exp <= &(bif.a ^ bif.b);
                    g_exp <= add_nc[WW];
`endif
                end else if (m_ov && bif.out_ready) begin
                    pend <= 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            chk($sformatf("c%0d.in_ready", CH), 128'(bif.in_ready), 128'(m_rdy));
            chk($sformatf("c%0d.out_valid", CH), 128'(bif.out_valid), 128'(m_ov));
            if (m_ov) begin
                chk($sformatf("c%0d.sum", CH), 128'(bif.sum), 128'(res[WW-1:0]));
                chk($sformatf("c%0d.cout", CH), 128'(bif.cout), 128'(res[WW]));
`ifdef CLA_SEQ_GROUP_PG_EN
                chk($sformatf("c%0d.p_all", CH), 128'(bif.p_all), 128'(p_exp));
                chk($sformatf("c%0d.g_all", CH), 128'(bif.g_all), 128'(g_exp));
`endif
            end
        end

        if (gi > 0) begin : rnd
            int           n_acc = 0;
            int           guard = 0;
            bit           take;
            logic [127:0] r;
            initial begin
                bif.in_valid  = 1'b0;
                bif.a         = '0;
                bif.b         = '0;
                bif.cin       = 1'b0;
                bif.out_ready = 1'b0;
                wait (rnd_go);
                while (n_acc < N_OPS && guard < 30000) begin
                    guard++;
                    @(negedge clk);
                    take = bif.in_valid && bif.in_ready;
                    @(posedge clk);
                    #1;
                    if (take) begin
                        n_acc++;
                        bif.in_valid = 1'b0;
                    end
                    bif.out_ready = ($urandom_range(0, 3) != 0);
                    if (!bif.in_valid && n_acc < N_OPS && $urandom_range(0, 2) != 0) begin
                        r = {$urandom, $urandom, $urandom, $urandom};
                        bif.a = ($urandom_range(0, 7) == 0) ? '1 : r[WW-1:0];
                        r = {$urandom, $urandom, $urandom, $urandom};
                        bif.b = ($urandom_range(0, 7) == 0) ? WW'(r[1:0]) : r[WW-1:0];
                        bif.cin = r[100];
                        bif.in_valid = 1'b1;
                    end
                end
                bif.in_valid  = 1'b0;
                bif.out_ready = 1'b1;
                repeat (12) @(posedge clk);
                rdone[gi] = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [45:0] a, input logic [45:0] b, input logic cin);
        u[0].bif.in_valid = 1'b1;
        u[0].bif.a        = a;
        u[0].bif.b        = b;
        u[0].bif.cin      = cin;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        u[0].bif.in_valid  = 1'b0;
        u[0].bif.a         = '0;
        u[0].bif.b         = '0;
        u[0].bif.cin       = 1'b0;
        u[0].bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready_low", 128'(u[0].bif.in_ready), 128'd0);
        chk("rst.out_valid", 128'(u[0].bif.out_valid), 128'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.in_ready", 128'(u[0].bif.in_ready), 128'd1);
        chk("post_rst.out_valid", 128'(u[0].bif.out_valid), 128'd0);
        chk("post_rst.sum", 128'(u[0].bif.sum), 128'd0);
        chk("post_rst.cout", 128'(u[0].bif.cout), 128'd0);

        // full carry ripple across both chunks
        step();
        put(46'h3FFF_FFFF_FFFF, 46'd1, 1'b0);
        step();
        u[0].bif.in_valid = 1'b0;
        step();
        chk("ripple.not_yet", 128'(u[0].bif.out_valid), 128'd0);
        step();
        chk("ripple.out_valid", 128'(u[0].bif.out_valid), 128'd1);
        chk("ripple.sum", 128'(u[0].bif.sum), 128'd0);
        chk("ripple.cout", 128'(u[0].bif.cout), 128'd1);
`ifdef CLA_SEQ_GROUP_PG_EN
        chk("ripple.p_all", 128'(u[0].bif.p_all), 128'd0);
        chk("ripple.g_all", 128'(u[0].bif.g_all), 128'd1);
`endif
        u[0].bif.out_ready = 1'b1;
        step();
        u[0].bif.out_ready = 1'b0;
        chk("ripple.drained", 128'(u[0].bif.out_valid), 128'd0);

        // carry from chunk 0 into chunk 1 via cin
        put(46'h0000_007F_FFFF, 46'd0, 1'b1);
        step();
        u[0].bif.in_valid = 1'b0;
        step();
        step();
        chk("xchunk.sum", 128'(u[0].bif.sum), 128'h80_0000);
        chk("xchunk.cout", 128'(u[0].bif.cout), 128'd0);
`ifdef CLA_SEQ_GROUP_PG_EN
        chk("xchunk.p_all", 128'(u[0].bif.p_all), 128'd0);
        chk("xchunk.g_all", 128'(u[0].bif.g_all), 128'd0);
`endif
        // backpressure: result holds, no new op accepted
        repeat (5) begin
            step();
            chk("bp.sum", 128'(u[0].bif.sum), 128'h80_0000);
            chk("bp.in_ready", 128'(u[0].bif.in_ready), 128'd0);
            chk("bp.out_valid", 128'(u[0].bif.out_valid), 128'd1);
        end
        u[0].bif.out_ready = 1'b1;
        put(46'd5, 46'd7, 1'b0);
        #1;
        chk("b2b.in_ready", 128'(u[0].bif.in_ready), 128'd1);
        step();
        u[0].bif.in_valid  = 1'b0;
        u[0].bif.out_ready = 1'b0;
        chk("b2b.run0", 128'(u[0].bif.out_valid), 128'd0);
        step();
        chk("b2b.run1", 128'(u[0].bif.out_valid), 128'd0);
        step();
        chk("b2b.out_valid", 128'(u[0].bif.out_valid), 128'd1);
        chk("b2b.sum", 128'(u[0].bif.sum), 128'd12);
        u[0].bif.out_ready = 1'b1;
        step();
        u[0].bif.out_ready = 1'b0;

        // reset in the middle of RUN discards the op
        put(46'd1, 46'd1, 1'b0);
        step();
        u[0].bif.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 128'(u[0].bif.out_valid), 128'd0);
        chk("midrst.in_ready", 128'(u[0].bif.in_ready), 128'd0);
        chk("midrst.sum", 128'(u[0].bif.sum), 128'd0);
        chk("midrst.cout", 128'(u[0].bif.cout), 128'd0);
        repeat (3) begin
            step();
            chk("midrst.hold", 128'(u[0].bif.out_valid), 128'd0);
        end
        rst = 1'b0;
        step();
        put(46'd100, 46'd23, 1'b1);
        step();
        u[0].bif.in_valid = 1'b0;
        step();
        step();
        chk("after_rst.out_valid", 128'(u[0].bif.out_valid), 128'd1);
        chk("after_rst.sum", 128'(u[0].bif.sum), 128'd124);
        u[0].bif.out_ready = 1'b1;
        step();
        u[0].bif.out_ready = 1'b0;

        rnd_go = 1'b1;
        k = 0;
        while (k < 40000 && !(rdone[1] && rdone[2])) begin
            @(posedge clk);
            k++;
        end
        if (!(rdone[1] && rdone[2])) begin
            n_vec++;
            n_bad++;
            $display("FAIL rnd.timeout: got %0d cycles expected completion", k);
        end
        chk("c1.results", 128'(u[1].n_res), 128'(N_OPS));
        chk("c4.results", 128'(u[2].n_res), 128'(N_OPS));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cla_seq_adder_ctrl.md
# cla_seq_adder_ctrl

Multi-cycle sequencer that performs wide additions of `CHUNKS`×23 bits by time-sharing a single `CLA_23bit` instance, one 23-bit chunk per clock, LSB chunk first. The block stores the inter-chunk carry and builds the wide result in a register. It presents a valid/ready handshake on both sides, so it sits between an operand producer and a result consumer in the datapath. It lets wide (e.g. extended-mantissa) adds reuse the existing 23-bit carry-lookahead adder instead of a full-width adder.

## Interface
- `CHUNKS`, default 2: number of 23-bit chunks per operand; legal range 1..8.
- `W`, default `CHUNKS*23`: operand width; derived, not overridden.
- `clk` in, 1: sole clock, rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `in_valid` in, 1: operands on `a`, `b`, `cin` are valid.
- `in_ready` out, 1: block accepts an operation this cycle.
- `a` in, W: addend.
- `b` in, W: addend.
- `cin` in, 1: carry into bit 0.
- `out_valid` out, 1: `sum`, `cout` (and group P/G) are valid.
- `out_ready` in, 1: consumer takes the result this cycle.
- `sum` out, W: registered result.
- `cout` out, 1: carry out of bit W-1.
- `p_all` out, 1: whole-width group propagate (only with `CLA_SEQ_GROUP_PG_EN`).
- `g_all` out, 1: whole-width group generate (only with `CLA_SEQ_GROUP_PG_EN`).

## Operation
- Exactly one `CLA_23bit` instance.
  - Its A/B inputs are muxed from captured operand registers by chunk index `idx`.
  - Its cin is `cin` for chunk 0, else the stored carry `c_reg`.
- Accept occurs when `in_valid && in_ready`.
  - Capture `a`, `b`, `cin`.
  - Clear `idx` to 0.
  - Go to RUN.
  - Inputs are ignored at all other times.
- States:
  - IDLE: `in_ready=1`, `out_valid=0`.
  - RUN: each cycle, write the adder S into `sum[idx*23 +: 23]` and the adder cout into `c_reg`, then increment `idx`. On `idx==CHUNKS-1`, latch `cout` from the adder cout and go to DONE. `in_ready=0`, `out_valid=0`.
  - DONE: `out_valid=1`. Hold `sum`/`cout` stable until `out_ready`.
- DONE exit:
  - On `out_ready` with no accept, go to IDLE.
  - On `out_ready` with a simultaneous accept, go directly to RUN.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`. `in_ready` is 0 while `rst` is high.
- Arithmetic is unsigned modulo 2^W; the overflow is reported only in `cout`.
- `sum` bits of chunks not yet processed retain their previous values during RUN. They are don't-care until `out_valid`.

## Timing
- Reset values: state IDLE, `idx=0`, `c_reg=0`, `sum=0`, `cout=0`, `out_valid=0`, `p_all=0`, `g_all=0`.
- Latency: accept on edge N gives `out_valid=1` after edge N+CHUNKS.
- Throughput: with `out_ready` held high, one result per CHUNKS+1 cycles (back-to-back accept in DONE).
- `CHUNKS=1`: RUN lasts one cycle; latency is 1.
- Backpressure: with `out_ready` low, DONE holds indefinitely and `in_ready` stays 0.
- Reset asserted mid-RUN or in DONE:
  - All state is cleared immediately.
  - The in-flight result is discarded, with no `out_valid` pulse.
- `out_valid` and `sum` are register outputs with no combinational path from inputs. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `CLA_SEQ_GROUP_PG_EN` defined:
  - The block adds ports `p_all`/`g_all` and accumulates the per-chunk group P/G from the adder.
  - At chunk 0: `p_acc=p0`, `g_acc=g0`.
  - At chunk k: `p_acc=p_acc&pk`, `g_acc=gk|(pk&g_acc)`.
  - The accumulators are registered, valid with `out_valid`, and held in DONE.
- Undefined: the ports and accumulator logic are absent; the datapath behaviour is otherwise identical.

## Test plan
- Reset check: assert `rst`, then release with `CHUNKS=2` → `in_ready=1`, `out_valid=0`, `sum=0`, `cout=0`; `in_ready` reads 0 while `rst` is high.
- Full carry ripple: `CHUNKS=2`, `a=46'h3FFF_FFFF_FFFF`, `b=1`, `cin=0` → after 2 cycles `out_valid=1`, `sum=0`, `cout=1`. With the macro: `p_all=0`, `g_all=1`.
- Cross-chunk carry: `a=46'h0000_007F_FFFF`, `b=0`, `cin=1` → `sum=46'h0000_0080_0000`, `cout=0`. With the macro: `p_all=0`, `g_all=0`.
- Backpressure and back-to-back:
  - Hold `out_ready=0` for 5 cycles in DONE → `sum` stable, `in_ready=0`.
  - Then raise `out_ready` with `in_valid=1`, `a=5`, `b=7` → the next result `sum=12` arrives 2 cycles later with no idle gap.
- Reset mid-operation: accept `a=1`, `b=1`, assert `rst` during RUN (`idx=1`) → no `out_valid`; all outputs at reset values; the next accepted op computes correctly.
- `CHUNKS=1` and `CHUNKS=4` random regression: 1000 ops with random valid/ready stalls → `{cout,sum}==a+b+cin` for every result, in order.
